// File: rtl/sw_key_accumulator_pkg.sv
// Shared DESim front-panel definitions: 7-seg glyph table, hex decode helper
// and pushbutton index assignments.
package sw_key_accumulator_pkg;

    localparam int ADD_KEY = 1;
    localparam int CLR_KEY = 2;

    localparam logic [6:0] HEX_BLANK = 7'b1111111;

    // Active-low segments, bit 0 = a ... bit 6 = g; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/sw_key_accumulator_key_conditioner.sv
// Pushbutton conditioner: 2-FF synchronizer, counter debounce, and a one-cycle
// press pulse on the debounced released->pressed transition.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic             db_dly_q;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter only runs while the synchronized level disagrees with db; any
    // agreeing sample restarts it, so short glitches never get through.
    always_comb begin
        db_d    = db_q;
        cnt_d   = '0;
        press_d = db_dly_q & ~db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            db_q     <= 1'b1;
            db_dly_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign level = db_q;
    assign press = press_q;

endmodule

// File: rtl/sw_key_accumulator.sv
// Front-panel accumulator: debounced KEY[1] adds SW[7:0] into a 16-bit sum,
// KEY[2] clears it; sum, operand and status are shown on HEX/LEDR.
module sw_key_accumulator
    import sw_key_accumulator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACC_W           = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    logic             add_level;
    logic             add_press;
    logic             clr_level;
    logic             clr_press;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [ACC_W:0]   sum;

    logic [6:0]       hex0_q;
    logic [6:0]       hex1_q;
    logic [6:0]       hex2_q;
    logic [6:0]       hex3_q;
    logic [6:0]       hex4_q;
    logic [6:0]       hex5_q;
    logic [9:0]       ledr_q;

    logic             unused_ok;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_add_key (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .key_n   (KEY[ADD_KEY]),
        .level   (add_level),
        .press   (add_press)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr_key (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .key_n   (KEY[CLR_KEY]),
        .level   (clr_level),
        .press   (clr_press)
    );

    // Clear has priority: a simultaneous add is dropped, not applied after.
    always_comb begin
        sum   = {1'b0, acc_q} + (ACC_W + 1)'(SW[7:0]);
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr_press) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add_press) begin
            acc_d = sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            hex0_q <= hex_to_seg(4'h0);
            hex1_q <= hex_to_seg(4'h0);
            hex2_q <= hex_to_seg(4'h0);
            hex3_q <= hex_to_seg(4'h0);
            hex4_q <= hex_to_seg(4'h0);
            hex5_q <= hex_to_seg(4'h0);
            ledr_q <= '0;
        end else begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            hex0_q <= hex_to_seg(acc_q[3:0]);
            hex1_q <= hex_to_seg(acc_q[7:4]);
            hex2_q <= hex_to_seg(acc_q[11:8]);
            hex3_q <= hex_to_seg(acc_q[15:12]);
            hex4_q <= hex_to_seg(SW[3:0]);
            hex5_q <= hex_to_seg(SW[7:4]);
            ledr_q <= {ovf_q, ~add_level, SW[7:0]};
        end
    end

    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;
    assign HEX3 = hex3_q;
    assign HEX4 = hex4_q;
    assign HEX5 = hex5_q;
    assign LEDR = ledr_q;

    // KEY[0], KEY[3], SW[9:8] and the clear key's level have no function here.
    assign unused_ok = &{1'b0, KEY[0], KEY[3], SW[9:8], clr_level};

endmodule

// File: tb/tb_sw_key_accumulator.sv
// Directed bench for sw_key_accumulator with a short debounce window.
module tb_sw_key_accumulator;

    localparam int DB = 4;

    logic       CLOCK_50;
    logic       reset;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  sw;
        logic        add;
        logic        clr;
        int          reps;
        logic [15:0] acc;
        logic        ovf;
    } vec_t;

    vec_t vecs [13];

    sw_key_accumulator #(
        .DEBOUNCE_CYCLES(DB),
        .ACC_W          (16)
    ) u_dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .KEY     (KEY),
        .SW      (SW),
        .LEDR    (LEDR),
        .HEX0    (HEX0),
        .HEX1    (HEX1),
        .HEX2    (HEX2),
        .HEX3    (HEX3),
        .HEX4    (HEX4),
        .HEX5    (HEX5)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] acc_glyphs(input logic [15:0] a);
        return {glyph(a[15:12]), glyph(a[11:8]), glyph(a[7:4]), glyph(a[3:0])};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic press_keys(input logic [7:0] sw, input logic add, input logic clr, input int reps);
        for (int r = 0; r < reps; r++) begin
            SW     = {2'b00, sw};
            KEY[1] = ~add;
            KEY[2] = ~clr;
            tick(8);
            KEY = 4'hF;
            tick(8);
        end
    endtask

    initial begin
        vecs[0]  = '{8'h00, 1'b0, 1'b1, 1,   16'h0000, 1'b0};
        vecs[1]  = '{8'h05, 1'b1, 1'b0, 1,   16'h0005, 1'b0};
        vecs[2]  = '{8'hFF, 1'b1, 1'b0, 1,   16'h0104, 1'b0};
        vecs[3]  = '{8'h80, 1'b1, 1'b0, 1,   16'h0184, 1'b0};
        vecs[4]  = '{8'h00, 1'b0, 1'b1, 1,   16'h0000, 1'b0};
        vecs[5]  = '{8'hFF, 1'b1, 1'b0, 256, 16'hFF00, 1'b0};
        vecs[6]  = '{8'hF0, 1'b1, 1'b0, 1,   16'hFFF0, 1'b0};
        vecs[7]  = '{8'h20, 1'b1, 1'b0, 1,   16'h0010, 1'b1};
        vecs[8]  = '{8'h05, 1'b1, 1'b0, 1,   16'h0015, 1'b1};
        vecs[9]  = '{8'h00, 1'b0, 1'b1, 1,   16'h0000, 1'b0};
        vecs[10] = '{8'h10, 1'b1, 1'b0, 1,   16'h0010, 1'b0};
        vecs[11] = '{8'h05, 1'b1, 1'b1, 1,   16'h0000, 1'b0};
        vecs[12] = '{8'h01, 1'b1, 1'b0, 3,   16'h0003, 1'b0};

        reset = 1'b1;
        KEY   = 4'hF;
        SW    = 10'h000;
        tick(3);
        check("reset_hex_acc", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, acc_glyphs(16'h0000)});
        check("reset_hex_sw", {18'h0, HEX5, HEX4}, {18'h0, glyph(4'h0), glyph(4'h0)});
        check("reset_ledr", {22'h0, LEDR}, 32'h0);

        // Key activity while reset is held must not reach the accumulator.
        SW     = 10'h011;
        KEY[1] = 1'b0;
        tick(12);
        KEY[1] = 1'b1;
        tick(12);
        check("reset_key_ignored", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, acc_glyphs(16'h0000)});
        check("reset_ledr_held", {22'h0, LEDR}, 32'h0);
        SW    = 10'h000;
        reset = 1'b0;
        tick(4);
        check("post_reset_acc", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, acc_glyphs(16'h0000)});

        // Press latency: pulse 2+DB+1 edges after the fall, acc one edge later,
        // HEX one more, so HEX changes exactly between tick 8 and tick 9.
        SW     = 10'h02A;
        KEY[1] = 1'b0;
        tick(8);
        check("latency_before", {25'h0, HEX0}, {25'h0, glyph(4'h0)});
        tick(1);
        check("latency_at", {18'h0, HEX1, HEX0}, {18'h0, glyph(4'h2), glyph(4'hA)});
        check("ledr8_pressed", {31'h0, LEDR[8]}, 32'h1);
        tick(1);
        KEY[1] = 1'b1;
        tick(12);
        check("single_add_held", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, acc_glyphs(16'h002A)});
        check("ledr98_after_release", {30'h0, LEDR[9:8]}, 32'h0);

        // Short glitch: only two synchronized low samples.
        KEY[1] = 1'b0;
        tick(2);
        KEY[1] = 1'b1;
        tick(12);
        check("glitch_no_add", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, acc_glyphs(16'h002A)});

        // Bounce: down, up, down, then settles low.
        SW     = 10'h001;
        KEY[1] = 1'b0;
        tick(1);
        KEY[1] = 1'b1;
        tick(1);
        KEY[1] = 1'b0;
        tick(10);
        KEY[1] = 1'b1;
        tick(12);
        check("bounce_one_add", {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, acc_glyphs(16'h002B)});

        for (int v = 0; v < 13; v++) begin
            press_keys(vecs[v].sw, vecs[v].add, vecs[v].clr, vecs[v].reps);
            check($sformatf("vec%0d_acc", v), {4'h0, HEX3, HEX2, HEX1, HEX0}, {4'h0, acc_glyphs(vecs[v].acc)});
            check($sformatf("vec%0d_ovf", v), {31'h0, LEDR[9]}, {31'h0, vecs[v].ovf});
            check($sformatf("vec%0d_ledr_sw", v), {24'h0, LEDR[7:0]}, {24'h0, vecs[v].sw});
        end

        // Switch path: one cycle latency, upper switches ignored.
        SW = 10'h3C7;
        #1;
        check("sw_not_yet", {24'h0, LEDR[7:0]}, 32'h01);
        tick(1);
        check("sw_hex5", {25'h0, HEX5}, {25'h0, 7'b1000110});
        check("sw_hex4", {25'h0, HEX4}, {25'h0, 7'b1111000});
        check("sw_ledr", {22'h0, LEDR}, {22'h0, 10'h0C7});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
